// File: rtl/adder_pipe_n_bit.sv
// adder_pipe_n_bit: STAGES-deep chunked ripple adder with valid/ready flow control.
// Define ADDER_SAT_EN to saturate the sum on signed overflow (default: wrapped sum).
module adder_pipe_n_bit #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cy,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam int unsigned CW   = WIDTH / STAGES;
    localparam int unsigned LAST = STAGES - 1;

    if (WIDTH % STAGES != 0) begin : g_bad_cfg
        $error("adder_pipe_n_bit: WIDTH must be a multiple of STAGES");
    end

    // Each stage carries the full operands (upper chunks still pending) and the
    // partial sum (lower chunks already resolved) plus the chunk carry-out.
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];
    logic             v_q [STAGES];
    logic [WIDTH-1:0] a_d [STAGES];
    logic [WIDTH-1:0] b_d [STAGES];
    logic [WIDTH-1:0] s_d [STAGES];
    logic             c_d [STAGES];
    logic             v_d [STAGES];

    logic             stall;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] src_s;
    logic             src_c;
    logic             src_v;
    logic [CW:0]      chunk;

    always_comb begin
        stall = v_q[LAST] && !out_ready;
        for (int unsigned k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                src_a = A;
                src_b = B;
                src_s = '0;
                src_c = Cin;
                src_v = in_valid;
            end else begin
                src_a = a_q[k-1];
                src_b = b_q[k-1];
                src_s = s_q[k-1];
                src_c = c_q[k-1];
                src_v = v_q[k-1];
            end
            chunk = {1'b0, src_a[k*CW +: CW]} + {1'b0, src_b[k*CW +: CW]}
                  + {{CW{1'b0}}, src_c};
            a_d[k]              = src_a;
            b_d[k]              = src_b;
            s_d[k]              = src_s;
            s_d[k][k*CW +: CW]  = chunk[CW-1:0];
            c_d[k]              = chunk[CW];
            v_d[k]              = src_v;
            // A full output with no taker freezes every stage at once.
            if (stall) begin
                a_d[k] = a_q[k];
                b_d[k] = b_q[k];
                s_d[k] = s_q[k];
                c_d[k] = c_q[k];
                v_d[k] = v_q[k];
            end
        end
    end

    always_comb begin
        in_ready  = !stall;
        out_valid = v_q[LAST];
        cy        = c_q[LAST];
        ovf       = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1])
                 && (s_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);
        sum       = s_q[LAST];
`ifdef ADDER_SAT_EN
        if (ovf) begin
            sum = {a_q[LAST][WIDTH-1], {(WIDTH-1){!a_q[LAST][WIDTH-1]}}};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
                v_q[k] <= 1'b0;
            end
        end else begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
                c_q[k] <= c_d[k];
                v_q[k] <= v_d[k];
            end
        end
    end

endmodule

// File: tb/tb_adder_pipe_n_bit.sv
// tb_adder_pipe_n_bit: directed corner cases plus randomized traffic against an
// arithmetic reference model and an in-order expectation queue.
module tb_adder_pipe_n_bit;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] A;
    logic [7:0] B;
    logic       Cin;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] sum;
    logic       cy;
    logic       ovf;
    logic       out_valid;
    logic       out_ready;

    int total = 0;
    int bad   = 0;

    adder_pipe_n_bit #(.WIDTH(8), .STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .cy        (cy),
        .ovf       (ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

`ifdef ADDER_SAT_EN
    localparam logic [9:0] EXP_NEG_OVF = 10'h380;
    localparam logic [9:0] EXP_POS_OVF = 10'h17F;
`else
    localparam logic [9:0] EXP_NEG_OVF = 10'h37F;
    localparam logic [9:0] EXP_POS_OVF = 10'h180;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Reference result packed as {cy, ovf, sum}, from integer arithmetic.
    function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic c);
        int unsigned u;
        int          s;
        logic [7:0]  r;
        logic        o;
        u = int'(a) + int'(b) + int'(c);
        s = int'($signed(a)) + int'($signed(b)) + int'(c);
        o = (s > 127) || (s < -128);
        r = u[7:0];
`ifdef ADDER_SAT_EN
        if (s > 127) r = 8'h7F;
        else if (s < -128) r = 8'h80;
`endif
        return {u[8], o, r};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic c, input logic v);
        A = a; B = b; Cin = c; in_valid = v;
    endtask

    logic [9:0] obs;
    assign obs = {cy, ovf, sum};

    logic [9:0] expq [$];
    logic [9:0] held;
    logic       stalled_prev;
    logic [9:0] r1, r2, r3;

    initial begin
        rst = 1'b1; out_ready = 1'b1;
        drive(8'h00, 8'h00, 1'b0, 1'b0);
        repeat (3) step();
        check("rst_out_valid", out_valid, 0);
        check("rst_result", obs, 10'h000);
        rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);

        // 01+01: result exactly two cycles after transfer
        drive(8'h01, 8'h01, 1'b0, 1'b1);
        step();
        drive(8'h00, 8'h00, 1'b0, 1'b0);
        check("lat1_out_valid", out_valid, 0);
        step();
        check("lat2_out_valid", out_valid, 1);
        check("sum_01_01", obs, 10'h002);
        step();

        // back-to-back with carry across chunks
        drive(8'hFF, 8'h01, 1'b1, 1'b1);
        step();
        drive(8'hAA, 8'h55, 1'b0, 1'b1);
        step();
        drive(8'h00, 8'h00, 1'b0, 1'b0);
        check("b2b_first_valid", out_valid, 1);
        check("sum_ff_01_c1", obs, 10'h201);
        step();
        check("b2b_second_valid", out_valid, 1);
        check("sum_aa_55", obs, 10'h0FF);
        step();

        // negative overflow
        drive(8'hB5, 8'hC9, 1'b1, 1'b1);
        step();
        drive(8'h00, 8'h00, 1'b0, 1'b0);
        step();
        check("neg_ovf", obs, EXP_NEG_OVF);
        step();

        // positive overflow
        drive(8'h7F, 8'h01, 1'b0, 1'b1);
        step();
        drive(8'h00, 8'h00, 1'b0, 1'b0);
        step();
        check("pos_ovf", obs, EXP_POS_OVF);
        step();

        // stall with three operand sets; third waits at the input until released
        r1 = model(8'h11, 8'h22, 1'b0);
        r2 = model(8'h33, 8'h44, 1'b1);
        r3 = model(8'h55, 8'h66, 1'b0);
        out_ready = 1'b1;
        drive(8'h11, 8'h22, 1'b0, 1'b1);
        step();
        drive(8'h33, 8'h44, 1'b1, 1'b1);
        step();
        drive(8'h55, 8'h66, 1'b0, 1'b1);
        out_ready = 1'b0;
        #1;
        check("stall_first_valid", out_valid, 1);
        check("stall_first_result", obs, r1);
        check("stall_in_ready", in_ready, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("stall_hold_in_ready", in_ready, 0);
            check("stall_hold_valid", out_valid, 1);
            check("stall_hold_result", obs, r1);
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", in_ready, 1);
        check("release_r1", obs, r1);
        step();
        drive(8'h00, 8'h00, 1'b0, 1'b0);
        check("release_r2_valid", out_valid, 1);
        check("release_r2", obs, r2);
        step();
        check("release_r3_valid", out_valid, 1);
        check("release_r3", obs, r3);
        step();
        check("release_empty", out_valid, 0);

        // reset one cycle after a transfer discards it
        drive(8'h12, 8'h34, 1'b0, 1'b1);
        step();
        drive(8'h00, 8'h00, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_sum", sum, 8'h00);
        check("rst_mid_in_ready", in_ready, 1);
        step();
        check("rst_discard_1", out_valid, 0);
        step();
        check("rst_discard_2", out_valid, 0);

        // randomized traffic with random back-pressure
        stalled_prev = 1'b0;
        held         = '0;
        for (int i = 0; i < 400; i++) begin
            A         = 8'($urandom);
            B         = 8'($urandom);
            Cin       = 1'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            check("in_ready_rule", in_ready, !(out_valid && !out_ready));
            if (stalled_prev) check("rand_stall_hold", {out_valid, obs}, {1'b1, held});
            if (in_valid && in_ready) expq.push_back(model(A, B, Cin));
            if (out_valid && out_ready) begin
                check("rand_expected_pending", expq.size() != 0, 1);
                if (expq.size() != 0) check("rand_out", obs, expq.pop_front());
            end
            stalled_prev = out_valid && !out_ready;
            held         = obs;
            step();
        end

        // drain
        drive(8'h00, 8'h00, 1'b0, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (out_valid) begin
                check("drain_expected_pending", expq.size() != 0, 1);
                if (expq.size() != 0) check("drain_out", obs, expq.pop_front());
            end
            step();
        end
        check("drain_empty", expq.size(), 0);
        check("drain_out_valid", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
